// File: rtl/ika87ad_opfetch.sv
// Opcode fetch front-end: bus fetch with one-level prefix paging, skip tagging and
// optional interrupt-opcode injection (enabled by defining IKA87AD_OPFETCH_IRQ_INJECT_EN).
module ika87ad_opfetch (
    input  logic       i_EMUCLK,
    input  logic       i_RESET_n,
    input  logic       i_MCUCLK_PCEN,
    input  logic       i_FETCH_REQ,
    output logic       o_BUS_RD,
    input  logic [7:0] i_BUS_DATA,
    input  logic       i_BUS_VALID,
    output logic       o_PC_INC,
    input  logic       i_SKIP,
    output logic       o_SKIP_CLR,
    input  logic       i_IRQ_PEND,
    output logic       o_IRQ_ACK,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_OP_SKIPPED,
    output logic       o_OP_VALID,
    input  logic       i_OP_ACK
);
    localparam logic [7:0] IRQ_OPCODE = 8'h73;

    typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] opcode, opcode_nxt;
    logic [2:0] page, page_nxt;
    logic       skipped, skipped_nxt;
    logic       injected, injected_nxt;
    logic       start, byte_take, ack_take, pc_inc;
    logic [2:0] page_in;

    function automatic logic [2:0] prefix_page(input logic [7:0] b);
        case (b)
            8'h48:   return 3'd1;
            8'h60:   return 3'd2;
            8'h64:   return 3'd3;
            8'h70:   return 3'd4;
            8'h74:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    assign page_in   = prefix_page(i_BUS_DATA);
    assign byte_take = i_MCUCLK_PCEN & i_BUS_VALID;
    assign ack_take  = i_MCUCLK_PCEN & i_OP_ACK & (state == HOLD);

    always_comb begin
        state_nxt    = state;
        opcode_nxt   = opcode;
        page_nxt     = page;
        skipped_nxt  = skipped;
        injected_nxt = injected;
        pc_inc       = 1'b0;
        start        = 1'b0;
        case (state)
            IDLE: start = i_MCUCLK_PCEN & i_FETCH_REQ;
            FETCH1: begin
                if (byte_take) begin
                    pc_inc = 1'b1;
                    if (page_in != 3'd0) begin
                        page_nxt  = page_in;
                        state_nxt = FETCH2;
                    end else begin
                        opcode_nxt = i_BUS_DATA;
                        page_nxt   = 3'd0;
                        state_nxt  = HOLD;
                    end
                end
            end
            // Second byte is always the opcode, even if it looks like a prefix.
            FETCH2: begin
                if (byte_take) begin
                    pc_inc     = 1'b1;
                    opcode_nxt = i_BUS_DATA;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (ack_take) begin
                    state_nxt = IDLE;
                    start     = i_FETCH_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            skipped_nxt  = i_SKIP;
            injected_nxt = 1'b0;
            state_nxt    = FETCH1;
`ifdef IKA87AD_OPFETCH_IRQ_INJECT_EN
            // A pending skip wins: the skipped instruction is fetched before any injection.
            if (i_IRQ_PEND && !i_SKIP) begin
                injected_nxt = 1'b1;
                opcode_nxt   = IRQ_OPCODE;
                page_nxt     = 3'd0;
                state_nxt    = HOLD;
            end
`endif
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RESET_n) begin
            state    <= IDLE;
            opcode   <= 8'h00;
            page     <= 3'd0;
            skipped  <= 1'b0;
            injected <= 1'b0;
        end else if (i_MCUCLK_PCEN) begin
            state    <= state_nxt;
            opcode   <= opcode_nxt;
            page     <= page_nxt;
            skipped  <= skipped_nxt;
            injected <= injected_nxt;
        end
    end

    assign o_BUS_RD      = (state == FETCH1) | (state == FETCH2);
    assign o_PC_INC      = i_RESET_n & pc_inc;
    assign o_SKIP_CLR    = i_RESET_n & ack_take & skipped;
    assign o_OPCODE      = opcode;
    assign o_OPCODE_PAGE = page;
    assign o_OP_SKIPPED  = skipped;
    assign o_OP_VALID    = (state == HOLD);

`ifdef IKA87AD_OPFETCH_IRQ_INJECT_EN
    assign o_IRQ_ACK = i_RESET_n & ack_take & injected;
`else
    logic unused_irq;
    assign unused_irq = i_IRQ_PEND ^ injected;
    assign o_IRQ_ACK  = 1'b0;
`endif

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Randomized bench for ika87ad_opfetch against a transaction-level fetch model.
module tb_ika87ad_opfetch;
    logic       clk = 1'b0, rst_n = 1'b0, pcen = 1'b1, fetch_req = 1'b0;
    logic       bus_valid = 1'b0, skip = 1'b0, irq = 1'b0, op_ack = 1'b0;
    logic [7:0] bus_data = 8'h00;
    logic       bus_rd, pc_inc, skip_clr, irq_ack, op_skipped, op_valid;
    logic [7:0] opcode;
    logic [2:0] opcode_page;

    int tests = 0, fails = 0;

`ifdef IKA87AD_OPFETCH_IRQ_INJECT_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [7:0] PFX [5] = '{8'h48, 8'h60, 8'h64, 8'h70, 8'h74};

    int         incs, en_cyc, unstable, clr_hold, iack_hold, e_incs;
    bit         rd_seen, tmo, clr_ack, iack_ack, valid_after, rd_after, e_rd;
    logic [7:0] e_op;
    logic [2:0] e_pg;

    ika87ad_opfetch dut (
        .i_EMUCLK(clk), .i_RESET_n(rst_n), .i_MCUCLK_PCEN(pcen), .i_FETCH_REQ(fetch_req),
        .o_BUS_RD(bus_rd), .i_BUS_DATA(bus_data), .i_BUS_VALID(bus_valid), .o_PC_INC(pc_inc),
        .i_SKIP(skip), .o_SKIP_CLR(skip_clr), .i_IRQ_PEND(irq), .o_IRQ_ACK(irq_ack),
        .o_OPCODE(opcode), .o_OPCODE_PAGE(opcode_page), .o_OP_SKIPPED(op_skipped),
        .o_OP_VALID(op_valid), .i_OP_ACK(op_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Expected result of one fetch: a prefix byte selects the page and the next byte is the opcode.
    function automatic void model(input logic [7:0] b0, input logic [7:0] b1, input bit sk, input bit ir,
                                  output logic [7:0] op, output logic [2:0] pg, output int n, output bit rd);
        if (IRQ_EN && ir && !sk) begin
            op = 8'h73; pg = 3'd0; n = 0; rd = 1'b0;
            return;
        end
        pg = 3'd0;
        for (int i = 0; i < 5; i++) if (b0 == PFX[i]) pg = 3'(i + 1);
        if (pg != 3'd0) begin op = b1; n = 2; end
        else begin op = b0; n = 1; end
        rd = 1'b1;
    endfunction

    // Drives one request and serves bus reads until o_OP_VALID; starts and ends just after a negedge.
    task automatic run_fetch(input logic [7:0] b0, input logic [7:0] b1, input bit sk, input bit ir,
                             input int gmin, input int gmax, input bit toggle, input bit no_req,
                             output int n_inc, output bit rd_s, output int n_en, output bit t_out);
        int idx, gap;
        bit req_done, taken;
        n_inc = 0; rd_s = 1'b0; n_en = 0; t_out = 1'b1; idx = 0;
        gap = int'($urandom_range(gmax, gmin)); req_done = no_req;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (op_valid === 1'b1) begin t_out = 1'b0; break; end
            pcen      = toggle ? (cyc % 2 == 1) : 1'b1;
            fetch_req = !req_done;
            skip      = req_done ? ($urandom() % 2 == 1) : sk;
            irq       = req_done ? ($urandom() % 2 == 1) : ir;
            op_ack    = ($urandom() % 2 == 1);
            bus_data  = 8'($urandom());
            bus_valid = 1'b0;
            if (bus_rd === 1'b1) begin
                rd_s = 1'b1;
                if (gap > 0) gap--;
                else begin bus_valid = 1'b1; bus_data = (idx == 0) ? b0 : b1; end
            end
            #1;
            if (pc_inc === 1'b1) n_inc++;
            if (pcen) n_en++;
            taken = pcen && bus_valid && (bus_rd === 1'b1);
            if (pcen) req_done = 1'b1;
            @(negedge clk);
            if (taken) begin idx++; gap = int'($urandom_range(gmax, gmin)); end
        end
        fetch_req = 1'b0; op_ack = 1'b0; bus_valid = 1'b0; pcen = 1'b1;
    endtask

    // Holds the presented opcode for a while (acks only while disabled), then acknowledges it.
    task automatic do_ack(input int hold, input bit req_next, input bit sk_next,
                          output int n_unst, output int n_clr, output int n_iack,
                          output bit c_ack, output bit i_ack, output bit v_after, output bit r_after);
        logic [7:0] op0;
        logic [2:0] pg0;
        logic       sk0;
        op0 = opcode; pg0 = opcode_page; sk0 = op_skipped;
        n_unst = 0; n_clr = 0; n_iack = 0;
        for (int i = 0; i < hold; i++) begin
            pcen = ($urandom() % 2 == 1); op_ack = !pcen; fetch_req = 1'b0;
            bus_valid = ($urandom() % 2 == 1); bus_data = 8'($urandom());
            #1;
            if (op_valid !== 1'b1 || opcode !== op0 || opcode_page !== pg0 || op_skipped !== sk0 || pc_inc !== 1'b0) n_unst++;
            if (skip_clr !== 1'b0) n_clr++;
            if (irq_ack !== 1'b0) n_iack++;
            @(negedge clk);
        end
        pcen = 1'b1; op_ack = 1'b1; fetch_req = req_next; skip = sk_next; irq = 1'b0; bus_valid = 1'b0;
        #1;
        c_ack = (skip_clr === 1'b1); i_ack = (irq_ack === 1'b1);
        @(negedge clk);
        op_ack = 1'b0; fetch_req = 1'b0;
        v_after = (op_valid === 1'b1); r_after = (bus_rd === 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; pcen = ($urandom() % 2 == 1); fetch_req = 1'b1; bus_valid = 1'b1;
        bus_data = 8'h48; op_ack = 1'b1; skip = 1'b1; irq = 1'b1;
        #1;
        tests++;
        if ({pc_inc, skip_clr, irq_ack} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses: got %b required 000", {pc_inc, skip_clr, irq_ack});
        end
        @(negedge clk);
        tests++;
        if ({bus_rd, pc_inc, skip_clr, irq_ack, op_valid, op_skipped, opcode, opcode_page} !== 17'd0) begin
            fails++;
            $display("FAIL reset_state: got ctl=%b op=%h pg=%0d required all zero",
                     {bus_rd, pc_inc, skip_clr, irq_ack, op_valid, op_skipped}, opcode, opcode_page);
        end
        rst_n = 1'b1; pcen = 1'b1; fetch_req = 1'b0; bus_valid = 1'b0; op_ack = 1'b0; skip = 1'b0; irq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_fetch(8'h54, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h54 || opcode_page !== 3'd0 || op_skipped !== 1'b0) begin
            fails++; $display("FAIL basic_opcode: got op=%h pg=%0d sk=%b tmo=%b required 54/0/0/0", opcode, opcode_page, op_skipped, tmo);
        end
        tests++;
        if (incs !== 1 || en_cyc !== 2) begin
            fails++; $display("FAIL basic_latency: got incs=%0d cycles=%0d required 1/2", incs, en_cyc);
        end
        do_ack(2, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (unstable !== 0 || clr_ack || iack_ack || valid_after || rd_after) begin
            fails++; $display("FAIL basic_ack: got unst=%0d clr=%b iack=%b v=%b rd=%b required 0/0/0/0/0", unstable, clr_ack, iack_ack, valid_after, rd_after);
        end
    endtask

    task automatic test_prefix();
        run_fetch(8'h70, 8'h6A, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h6A || opcode_page !== 3'd4 || incs !== 2 || en_cyc !== 3) begin
            fails++; $display("FAIL prefix_70: got op=%h pg=%0d incs=%0d cycles=%0d required 6a/4/2/3", opcode, opcode_page, incs, en_cyc);
        end
        do_ack(1, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        run_fetch(8'h48, 8'h48, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h48 || opcode_page !== 3'd1 || incs !== 2) begin
            fails++; $display("FAIL prefix_48_48: got op=%h pg=%0d incs=%0d required 48/1/2", opcode, opcode_page, incs);
        end
        do_ack(0, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
    endtask

    task automatic test_skip();
        run_fetch(8'h26, 8'h00, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h26 || opcode_page !== 3'd0 || op_skipped !== 1'b1) begin
            fails++; $display("FAIL skip_opcode: got op=%h pg=%0d sk=%b required 26/0/1", opcode, opcode_page, op_skipped);
        end
        do_ack(3, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (clr_hold !== 0 || !clr_ack || unstable !== 0 || valid_after) begin
            fails++; $display("FAIL skip_clr: got early=%0d at_ack=%b unst=%0d v=%b required 0/1/0/0", clr_hold, clr_ack, unstable, valid_after);
        end
    endtask

    task automatic test_pcen();
        logic [7:0] c0 [2];
        logic [7:0] c1 [2];
        c0[0] = 8'h54; c1[0] = 8'h00; c0[1] = 8'h70; c1[1] = 8'h6A;
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 2; t++) begin
                run_fetch(c0[k], c1[k], 1'b0, 1'b0, 3, 3, t == 1, 1'b0, incs, rd_seen, en_cyc, tmo);
                model(c0[k], c1[k], 1'b0, 1'b0, e_op, e_pg, e_incs, e_rd);
                tests++;
                if (tmo || opcode !== e_op || opcode_page !== e_pg || op_skipped !== 1'b0 || incs !== e_incs) begin
                    fails++; $display("FAIL pcen_case%0d_toggle%0d: got op=%h pg=%0d incs=%0d required %h/%0d/%0d", k, t, opcode, opcode_page, incs, e_op, e_pg, e_incs);
                end
                do_ack(2, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
            end
        end
    endtask

    task automatic test_reset_fetch2();
        pcen = 1'b1; fetch_req = 1'b1; skip = 1'b0; irq = 1'b0; bus_valid = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0; bus_valid = 1'b1; bus_data = 8'h64;
        #1;
        tests++;
        if (bus_rd !== 1'b1 || pc_inc !== 1'b1) begin
            fails++; $display("FAIL rst_f2_prefix: got rd=%b inc=%b required 1/1", bus_rd, pc_inc);
        end
        @(negedge clk);
        rst_n = 1'b0; pcen = ($urandom() % 2 == 1); bus_valid = 1'b1; bus_data = 8'h99; op_ack = 1'b1;
        #1;
        tests++;
        if (pc_inc !== 1'b0) begin
            fails++; $display("FAIL rst_f2_no_inc: got inc=%b required 0", pc_inc);
        end
        @(negedge clk);
        tests++;
        if ({bus_rd, pc_inc, skip_clr, irq_ack, op_valid, op_skipped, opcode, opcode_page} !== 17'd0) begin
            fails++; $display("FAIL rst_f2_state: got rd=%b v=%b op=%h pg=%0d required all zero", bus_rd, op_valid, opcode, opcode_page);
        end
        rst_n = 1'b1; bus_valid = 1'b0; op_ack = 1'b0; pcen = 1'b1;
        @(negedge clk);
        run_fetch(8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h00 || opcode_page !== 3'd0 || incs !== 1) begin
            fails++; $display("FAIL rst_f2_refetch: got op=%h pg=%0d incs=%0d required 00/0/1", opcode, opcode_page, incs);
        end
        do_ack(0, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
    endtask

    task automatic test_irq();
        run_fetch(8'h54, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        model(8'h54, 8'h00, 1'b0, 1'b1, e_op, e_pg, e_incs, e_rd);
        tests++;
        if (tmo || opcode !== e_op || opcode_page !== e_pg || incs !== e_incs || rd_seen !== e_rd) begin
            fails++; $display("FAIL irq_inject: got op=%h pg=%0d incs=%0d rd=%b required %h/%0d/%0d/%b", opcode, opcode_page, incs, rd_seen, e_op, e_pg, e_incs, e_rd);
        end
        do_ack(2, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (iack_ack !== IRQ_EN || iack_hold !== 0 || clr_ack) begin
            fails++; $display("FAIL irq_ack: got at_ack=%b early=%0d clr=%b required %b/0/0", iack_ack, iack_hold, clr_ack, IRQ_EN);
        end
        run_fetch(8'h11, 8'h00, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h11 || op_skipped !== 1'b1 || !rd_seen) begin
            fails++; $display("FAIL irq_skip_first: got op=%h sk=%b rd=%b required 11/1/1", opcode, op_skipped, rd_seen);
        end
        do_ack(1, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (iack_ack || !clr_ack) begin
            fails++; $display("FAIL irq_skip_ack: got iack=%b clr=%b required 0/1", iack_ack, clr_ack);
        end
        run_fetch(8'h22, 8'h00, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        model(8'h22, 8'h00, 1'b0, 1'b1, e_op, e_pg, e_incs, e_rd);
        tests++;
        if (tmo || opcode !== e_op || incs !== e_incs || rd_seen !== e_rd) begin
            fails++; $display("FAIL irq_after_skip: got op=%h incs=%0d rd=%b required %h/%0d/%b", opcode, incs, rd_seen, e_op, e_incs, e_rd);
        end
        do_ack(0, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
    endtask

    task automatic test_back_to_back();
        run_fetch(8'h60, 8'h3C, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h3C || opcode_page !== 3'd2) begin
            fails++; $display("FAIL b2b_first: got op=%h pg=%0d required 3c/2", opcode, opcode_page);
        end
        do_ack(0, 1'b1, 1'b1, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (valid_after || !rd_after || clr_ack) begin
            fails++; $display("FAIL b2b_direct: got v=%b rd=%b clr=%b required 0/1/0", valid_after, rd_after, clr_ack);
        end
        run_fetch(8'h74, 8'h74, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, incs, rd_seen, en_cyc, tmo);
        tests++;
        if (tmo || opcode !== 8'h74 || opcode_page !== 3'd5 || op_skipped !== 1'b1 || incs !== 2) begin
            fails++; $display("FAIL b2b_second: got op=%h pg=%0d sk=%b incs=%0d required 74/5/1/2", opcode, opcode_page, op_skipped, incs);
        end
        do_ack(1, 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
        tests++;
        if (!clr_ack || unstable !== 0) begin
            fails++; $display("FAIL b2b_clr: got clr=%b unst=%0d required 1/0", clr_ack, unstable);
        end
    endtask

    task automatic test_random();
        logic [7:0] b0, b1;
        bit         sk, ir, tg;
        int         gmax;
        for (int n = 0; n < 40; n++) begin
            b0   = ($urandom() % 3 == 0) ? PFX[$urandom() % 5] : 8'($urandom());
            b1   = ($urandom() % 4 == 0) ? PFX[$urandom() % 5] : 8'($urandom());
            sk   = ($urandom() % 4 == 0);
            ir   = ($urandom() % 3 == 0);
            tg   = ($urandom() % 2 == 1);
            gmax = int'($urandom_range(3, 0));
            run_fetch(b0, b1, sk, ir, 0, gmax, tg, 1'b0, incs, rd_seen, en_cyc, tmo);
            model(b0, b1, sk, ir, e_op, e_pg, e_incs, e_rd);
            tests++;
            if (tmo || opcode !== e_op || opcode_page !== e_pg || op_skipped !== sk || incs !== e_incs || rd_seen !== e_rd) begin
                fails++;
                $display("FAIL rand%0d_fetch: got op=%h pg=%0d sk=%b incs=%0d rd=%b tmo=%b required %h/%0d/%b/%0d/%b/0",
                         n, opcode, opcode_page, op_skipped, incs, rd_seen, tmo, e_op, e_pg, sk, e_incs, e_rd);
            end
            do_ack(int'($urandom_range(2, 0)), 1'b0, 1'b0, unstable, clr_hold, iack_hold, clr_ack, iack_ack, valid_after, rd_after);
            tests++;
            if (unstable !== 0 || clr_hold !== 0 || iack_hold !== 0 || clr_ack !== sk ||
                iack_ack !== (IRQ_EN && ir && !sk) || valid_after) begin
                fails++;
                $display("FAIL rand%0d_ack: got unst=%0d clr=%b iack=%b v=%b required 0/%b/%b/0",
                         n, unstable, clr_ack, iack_ack, valid_after, sk, IRQ_EN && ir && !sk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_skip();
        test_pcen();
        test_reset_fetch2();
        test_irq();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
